// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter states,
// the BTB entry layout and the saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_e;

  localparam int unsigned BP_WIDTH    = 32;
  localparam int unsigned BP_TAG_BITS = 8;

  // Entry layout for the default geometry; bp_btb derives its own from its parameters.
  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_WIDTH-1:0]    target;
  } btb_entry_t;

  localparam pht_state_e PHT_RESET = WNT;

  function automatic pht_state_e sat_update(input pht_state_e state, input logic taken);
    pht_state_e nxt;
    case (state)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      default: nxt = taken ? ST  : WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: two combinational read ports (Fetch and
// Execute), one synchronous write port, asynchronous clear.
module bp_btb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned IDX      = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX-1:0]      i_rd_idx_f,
  input  logic [TAG_BITS-1:0] i_rd_tag_f,
  output logic                o_hit_f,
  output logic [WIDTH-1:0]    o_target_f,
  input  logic [IDX-1:0]      i_rd_idx_e,
  input  logic [TAG_BITS-1:0] i_rd_tag_e,
  output logic                o_hit_e,
  input  logic                i_we,
  input  logic [IDX-1:0]      i_wr_idx,
  input  logic [TAG_BITS-1:0] i_wr_tag,
  input  logic [WIDTH-1:0]    i_wr_target
);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [WIDTH-1:0]    target;
  } entry_t;

  entry_t r_mem [ENTRIES];
  entry_t w_ent_f;
  entry_t w_ent_e;

  assign w_ent_f    = r_mem[i_rd_idx_f];
  assign w_ent_e    = r_mem[i_rd_idx_e];
  assign o_hit_f    = w_ent_f.valid && (w_ent_f.tag == i_rd_tag_f);
  assign o_target_f = w_ent_f.target;
  assign o_hit_e    = w_ent_e.valid && (w_ent_e.tag == i_rd_tag_e);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wr_idx] <= '{valid: 1'b1, tag: i_wr_tag, target: i_wr_target};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB + 2-bit PHT lookup in Fetch, update and
// mispredict detection in Execute. Define BP_GSHARE_EN to XOR a GHR into the PHT index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  output logic             pred_taken_f,
  output logic [WIDTH-1:0] pred_next_pc_f,
  input  logic             upd_valid_e,
  input  logic [WIDTH-1:0] upd_pc_e,
  input  logic             upd_is_jump_e,
  input  logic             upd_taken_e,
  input  logic [WIDTH-1:0] upd_target_e,
  input  logic             upd_pred_taken_e,
  input  logic [WIDTH-1:0] upd_pred_next_pc_e,
  output logic             mispredict_e,
  output logic [WIDTH-1:0] redirect_pc_e,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  logic [IDX-1:0]      w_idx_f;
  logic [IDX-1:0]      w_idx_e;
  logic [TAG_BITS-1:0] w_tag_f;
  logic [TAG_BITS-1:0] w_tag_e;
  logic [IDX-1:0]      w_pht_idx_f;
  logic [IDX-1:0]      w_pht_idx_e;
  logic                w_hit_f;
  logic                w_hit_e;
  logic [WIDTH-1:0]    w_target_f;
  logic [WIDTH-1:0]    w_pc_plus4_f;
  logic [WIDTH-1:0]    w_pc_plus4_e;
  logic [WIDTH-1:0]    w_correct_pc_e;
  logic                w_unused;

  pht_state_e  r_pht [ENTRIES];
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  assign w_idx_f = pc_f[IDX+1:2];
  assign w_idx_e = upd_pc_e[IDX+1:2];
  assign w_tag_f = pc_f[IDX+2+TAG_BITS-1:IDX+2];
  assign w_tag_e = upd_pc_e[IDX+2+TAG_BITS-1:IDX+2];

  // Mispredicts are detected by next-PC comparison, so the carried direction bit is not needed.
  assign w_unused = upd_pred_taken_e;

`ifdef BP_GSHARE_EN
  logic [IDX-1:0] r_ghr;

  assign w_pht_idx_f = w_idx_f ^ r_ghr;
  assign w_pht_idx_e = w_idx_e ^ r_ghr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (upd_valid_e && !upd_is_jump_e) begin
      r_ghr <= {r_ghr[IDX-2:0], upd_taken_e};
    end
  end
`else
  assign w_pht_idx_f = w_idx_f;
  assign w_pht_idx_e = w_idx_e;
`endif

  bp_btb #(
    .WIDTH    (WIDTH),
    .ENTRIES  (ENTRIES),
    .TAG_BITS (TAG_BITS),
    .IDX      (IDX)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx_f  (w_idx_f),
    .i_rd_tag_f  (w_tag_f),
    .o_hit_f     (w_hit_f),
    .o_target_f  (w_target_f),
    .i_rd_idx_e  (w_idx_e),
    .i_rd_tag_e  (w_tag_e),
    .o_hit_e     (w_hit_e),
    .i_we        (upd_valid_e && upd_taken_e),
    .i_wr_idx    (w_idx_e),
    .i_wr_tag    (w_tag_e),
    .i_wr_target (upd_target_e)
  );

  assign w_pc_plus4_f   = pc_f + WIDTH'(4);
  assign pred_taken_f   = w_hit_f && r_pht[w_pht_idx_f][1];
  assign pred_next_pc_f = pred_taken_f ? w_target_f : w_pc_plus4_f;

  assign w_pc_plus4_e   = upd_pc_e + WIDTH'(4);
  assign w_correct_pc_e = (upd_valid_e && upd_taken_e) ? upd_target_e : w_pc_plus4_e;
  assign mispredict_e   = upd_valid_e && (upd_pred_next_pc_e != w_correct_pc_e);
  assign redirect_pc_e  = w_correct_pc_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_pht[i] <= PHT_RESET;
      end
    end else if (upd_valid_e) begin
      if (upd_is_jump_e) begin
        r_pht[w_pht_idx_e] <= ST;
      end else if (w_hit_e) begin
        r_pht[w_pht_idx_e] <= sat_update(r_pht[w_pht_idx_e], upd_taken_e);
      end else if (upd_taken_e) begin
        r_pht[w_pht_idx_e] <= WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (upd_valid_e) begin
      if (r_br_count != '1) r_br_count <= r_br_count + 32'd1;
      if (mispredict_e && (r_mispred_count != '1)) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, ENTRIES=64).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_next_pc_f;
  logic        upd_valid_e;
  logic [31:0] upd_pc_e;
  logic        upd_is_jump_e;
  logic        upd_taken_e;
  logic [31:0] upd_target_e;
  logic        upd_pred_taken_e;
  logic [31:0] upd_pred_next_pc_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int total = 0;
  int bad   = 0;

  branch_predictor #(
    .WIDTH    (32),
    .ENTRIES  (64),
    .TAG_BITS (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pc_f               (pc_f),
    .pred_taken_f       (pred_taken_f),
    .pred_next_pc_f     (pred_next_pc_f),
    .upd_valid_e        (upd_valid_e),
    .upd_pc_e           (upd_pc_e),
    .upd_is_jump_e      (upd_is_jump_e),
    .upd_taken_e        (upd_taken_e),
    .upd_target_e       (upd_target_e),
    .upd_pred_taken_e   (upd_pred_taken_e),
    .upd_pred_next_pc_e (upd_pred_next_pc_e),
    .mispredict_e       (mispredict_e),
    .redirect_pc_e      (redirect_pc_e),
    .br_count           (br_count),
    .mispred_count      (mispred_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive_upd(input logic [31:0] pc, input logic jump, input logic taken,
                           input logic [31:0] target, input logic [31:0] pn);
    upd_valid_e        = 1'b1;
    upd_pc_e           = pc;
    upd_is_jump_e      = jump;
    upd_taken_e        = taken;
    upd_target_e       = target;
    upd_pred_taken_e   = (pn != pc + 32'd4);
    upd_pred_next_pc_e = pn;
  endtask

  task automatic idle();
    upd_valid_e = 1'b0;
  endtask

  // Advance one rising edge and return to the falling edge for driving/sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pc_f = 32'h100;
    idle();
    upd_pc_e = 32'h0; upd_is_jump_e = 1'b0; upd_taken_e = 1'b0;
    upd_target_e = 32'h0; upd_pred_taken_e = 1'b0; upd_pred_next_pc_e = 32'h0;
    #1;
    total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0h want=0", pred_taken_f); end
    total++; if (pred_next_pc_f !== 32'h104) begin bad++; $display("FAIL reset_next got=%0h want=104", pred_next_pc_f); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL reset_br got=%0d want=0", br_count); end
    total++; if (mispred_count !== 32'd0) begin bad++; $display("FAIL reset_mis got=%0d want=0", mispred_count); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_alloc();
    pc_f = 32'h100;
    drive_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    #1;
    total++; if (mispredict_e !== 1'b1) begin bad++; $display("FAIL alloc_mis got=%0h want=1", mispredict_e); end
    total++; if (redirect_pc_e !== 32'h80) begin bad++; $display("FAIL alloc_redir got=%0h want=80", redirect_pc_e); end
    total++; if (pred_next_pc_f !== 32'h104) begin bad++; $display("FAIL same_cycle_old got=%0h want=104", pred_next_pc_f); end
    step();
    idle();
    #1;
    total++; if (mispred_count !== 32'd1) begin bad++; $display("FAIL alloc_miscnt got=%0d want=1", mispred_count); end
    total++; if (br_count !== 32'd1) begin bad++; $display("FAIL alloc_brcnt got=%0d want=1", br_count); end
    total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%0h want=1", pred_taken_f); end
    total++; if (pred_next_pc_f !== 32'h80) begin bad++; $display("FAIL alloc_next got=%0h want=80", pred_next_pc_f); end
    step();
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 2; i++) begin
      drive_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h80);
      #1;
      total++; if (mispredict_e !== 1'b0) begin bad++; $display("FAIL hyst_t%0d_mis got=%0h want=0", i, mispredict_e); end
      step();
    end
    drive_upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h80);
    #1;
    total++; if (mispredict_e !== 1'b1) begin bad++; $display("FAIL hyst_nt1_mis got=%0h want=1", mispredict_e); end
    total++; if (redirect_pc_e !== 32'h104) begin bad++; $display("FAIL hyst_nt1_redir got=%0h want=104", redirect_pc_e); end
    step();
    idle();
    #1;
    total++; if (pred_next_pc_f !== 32'h80) begin bad++; $display("FAIL hyst_nt1_next got=%0h want=80", pred_next_pc_f); end
    step();
    drive_upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h80);
    step();
    idle();
    #1;
    total++; if (pred_next_pc_f !== 32'h104) begin bad++; $display("FAIL hyst_nt2_next got=%0h want=104", pred_next_pc_f); end
    total++; if (br_count !== 32'd5) begin bad++; $display("FAIL hyst_brcnt got=%0d want=5", br_count); end
    total++; if (mispred_count !== 32'd3) begin bad++; $display("FAIL hyst_miscnt got=%0d want=3", mispred_count); end
    step();
  endtask

  task automatic test_alias();
    // Retrain WNT -> WT so 0x100 predicts taken again before being evicted.
    drive_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    step();
    idle();
    #1;
    total++; if (pred_next_pc_f !== 32'h80) begin bad++; $display("FAIL alias_retrain got=%0h want=80", pred_next_pc_f); end
    pc_f = 32'h200;
    #1;
    total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL alias_miss_taken got=%0h want=0", pred_taken_f); end
    total++; if (pred_next_pc_f !== 32'h204) begin bad++; $display("FAIL alias_miss_next got=%0h want=204", pred_next_pc_f); end
    step();
    drive_upd(32'h200, 1'b0, 1'b1, 32'h300, 32'h204);
    #1;
    total++; if (mispredict_e !== 1'b1) begin bad++; $display("FAIL alias_upd_mis got=%0h want=1", mispredict_e); end
    step();
    idle();
    #1;
    total++; if (pred_next_pc_f !== 32'h300) begin bad++; $display("FAIL alias_new_next got=%0h want=300", pred_next_pc_f); end
    pc_f = 32'h100;
    #1;
    total++; if (pred_next_pc_f !== 32'h104) begin bad++; $display("FAIL alias_evicted got=%0h want=104", pred_next_pc_f); end
    step();
  endtask

  task automatic test_target_change();
    pc_f = 32'h100;
    drive_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    step();
    drive_upd(32'h100, 1'b0, 1'b1, 32'h90, 32'h80);
    #1;
    total++; if (mispredict_e !== 1'b1) begin bad++; $display("FAIL tgt_mis got=%0h want=1", mispredict_e); end
    total++; if (redirect_pc_e !== 32'h90) begin bad++; $display("FAIL tgt_redir got=%0h want=90", redirect_pc_e); end
    total++; if (pred_next_pc_f !== 32'h80) begin bad++; $display("FAIL tgt_same_cycle got=%0h want=80", pred_next_pc_f); end
    step();
    idle();
    #1;
    total++; if (pred_next_pc_f !== 32'h90) begin bad++; $display("FAIL tgt_next got=%0h want=90", pred_next_pc_f); end
    step();
  endtask

  task automatic test_jump();
    pc_f = 32'h104;
    drive_upd(32'h104, 1'b1, 1'b1, 32'h400, 32'h108);
    #1;
    total++; if (mispredict_e !== 1'b1) begin bad++; $display("FAIL jump_mis got=%0h want=1", mispredict_e); end
    step();
    // A jump forces ST, so one not-taken conditional must still leave it predicting taken.
    drive_upd(32'h104, 1'b0, 1'b0, 32'h400, 32'h400);
    #1;
    total++; if (redirect_pc_e !== 32'h108) begin bad++; $display("FAIL jump_nt_redir got=%0h want=108", redirect_pc_e); end
    step();
    idle();
    #1;
    total++; if (pred_next_pc_f !== 32'h400) begin bad++; $display("FAIL jump_st_next got=%0h want=400", pred_next_pc_f); end
    step();
  endtask

  task automatic test_invalid_and_wrap();
    idle();
    upd_pc_e = 32'h10; upd_taken_e = 1'b1; upd_target_e = 32'h999; upd_pred_next_pc_e = 32'h0;
    #1;
    total++; if (mispredict_e !== 1'b0) begin bad++; $display("FAIL inval_mis got=%0h want=0", mispredict_e); end
    total++; if (redirect_pc_e !== 32'h14) begin bad++; $display("FAIL inval_redir got=%0h want=14", redirect_pc_e); end
    upd_pc_e = 32'hFFFF_FFFC;
    pc_f = 32'hFFFF_FFFC;
    #1;
    total++; if (redirect_pc_e !== 32'h0) begin bad++; $display("FAIL wrap_redir got=%0h want=0", redirect_pc_e); end
    total++; if (pred_next_pc_f !== 32'h0) begin bad++; $display("FAIL wrap_next got=%0h want=0", pred_next_pc_f); end
    step();
    total++; if (br_count !== 32'd11) begin bad++; $display("FAIL inval_brcnt got=%0d want=11", br_count); end
  endtask

  task automatic test_back_to_back();
    pc_f = 32'h108;
    drive_upd(32'h108, 1'b0, 1'b1, 32'h500, 32'h10C);
    step();
    drive_upd(32'h108, 1'b0, 1'b1, 32'h500, 32'h500);
    #1;
    total++; if (pred_next_pc_f !== 32'h500) begin bad++; $display("FAIL b2b_visible got=%0h want=500", pred_next_pc_f); end
    total++; if (mispredict_e !== 1'b0) begin bad++; $display("FAIL b2b_mis2 got=%0h want=0", mispredict_e); end
    step();
    drive_upd(32'h108, 1'b0, 1'b0, 32'h500, 32'h500);
    step();
    idle();
    #1;
    total++; if (br_count !== 32'd14) begin bad++; $display("FAIL b2b_brcnt got=%0d want=14", br_count); end
    total++; if (mispred_count !== 32'd11) begin bad++; $display("FAIL b2b_miscnt got=%0d want=11", mispred_count); end
    total++; if (pred_next_pc_f !== 32'h500) begin bad++; $display("FAIL b2b_wt_next got=%0h want=500", pred_next_pc_f); end
    step();
  endtask

  task automatic test_async_reset();
    pc_f = 32'h100;
    #1;
    total++; if (pred_next_pc_f !== 32'h90) begin bad++; $display("FAIL arst_pre got=%0h want=90", pred_next_pc_f); end
    rst = 1'b0;
    #1;
    total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL arst_taken got=%0h want=0", pred_taken_f); end
    total++; if (pred_next_pc_f !== 32'h104) begin bad++; $display("FAIL arst_next got=%0h want=104", pred_next_pc_f); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL arst_br got=%0d want=0", br_count); end
    total++; if (mispred_count !== 32'd0) begin bad++; $display("FAIL arst_mis got=%0d want=0", mispred_count); end
    @(negedge clk);
    rst = 1'b1;
    step();
    pc_f = 32'h108;
    #1;
    total++; if (pred_next_pc_f !== 32'h10C) begin bad++; $display("FAIL arst_cleared got=%0h want=10c", pred_next_pc_f); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_target_change();
    test_jump();
    test_invalid_and_wrap();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
